// File: rtl/mixer_pkg.sv
// Shared defaults and types for the mixer_pipe slice.
// Rounding is enabled in the sub-module when MIXER_ROUND_EN is defined.
package mixer_pkg;
   localparam int MIX_DW        = 20;
   localparam int MIX_GW        = 25;
   localparam int MIX_LO_FRAC   = 15;
   localparam int MIX_GAIN_FRAC = 23;
   // 0.6309573 * 0.5 in Q2.23
   localparam logic [MIX_GW-1:0] MIX_GAIN_RST = 25'h028_619A;
   localparam int SAT_CNT_W     = 16;

   typedef logic signed [MIX_DW-1:0] sample_t;
endpackage

// File: rtl/mixer_shift_sat.sv
// Arithmetic right shift (round half-up under MIXER_ROUND_EN) followed by
// signed saturation to OUT_W bits with a clip flag.
module mixer_shift_sat
   import mixer_pkg::*;
#(
   parameter int IN_W  = 2 * MIX_DW,
   parameter int SHIFT = MIX_LO_FRAC,
   parameter int OUT_W = MIX_DW
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout,
   output logic             sat
);
   // One guard bit so the rounding add can never overflow.
   localparam int EW = IN_W + 1;
   localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [EW-1:0] ext_s;
   logic signed [EW-1:0] rnd_s;
   logic signed [EW-1:0] shf_s;

   assign ext_s = {din[IN_W-1], din};
`ifdef MIXER_ROUND_EN
   localparam logic signed [EW-1:0] HALF_V = {{(EW-1){1'b0}}, 1'b1} << (SHIFT - 1);
   assign rnd_s = ext_s + HALF_V;
`else
   assign rnd_s = ext_s;
`endif
   assign shf_s = rnd_s >>> SHIFT;

   // Clip the shifted value into the signed OUT_W range.
   always_comb begin
      dout = shf_s[OUT_W-1:0];
      sat  = 1'b0;
      if (shf_s > MAX_V) begin
         dout = MAX_V[OUT_W-1:0];
         sat  = 1'b1;
      end else if (shf_s < MIN_V) begin
         dout = MIN_V[OUT_W-1:0];
         sat  = 1'b1;
      end else begin
         dout = shf_s[OUT_W-1:0];
         sat  = 1'b0;
      end
   end
endmodule

// File: rtl/mixer_pipe.sv
// Two-stage pipelined mixer: interp*LO, then *gain, each stage saturated,
// with valid/ready flow control. Optional rounding via MIXER_ROUND_EN.
module mixer_pipe
   import mixer_pkg::*;
#(
   parameter int              DW        = MIX_DW,
   parameter int              LO_FRAC   = MIX_LO_FRAC,
   parameter int              GW        = MIX_GW,
   parameter int              GAIN_FRAC = MIX_GAIN_FRAC,
   parameter logic [GW-1:0]   GAIN_RST  = MIX_GAIN_RST
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DW-1:0]        interp_i,
   input  logic [DW-1:0]        lo_i,
   input  logic [GW-1:0]        gain_i,
   input  logic                 gain_we,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        mix_o,
   output logic                 sat_o,
   output logic [SAT_CNT_W-1:0] sat_cnt
);
   logic                    adv_s;
   logic                    s1_valid_r;
   logic [DW-1:0]           p1_r;
   logic                    s1_sat_r;
   logic [GW-1:0]           gain_r;

   logic signed [2*DW-1:0]  interp_x_s;
   logic signed [2*DW-1:0]  lo_x_s;
   logic signed [2*DW-1:0]  prod1_s;
   logic signed [DW+GW-1:0] p1_x_s;
   logic signed [DW+GW-1:0] gain_x_s;
   logic signed [DW+GW-1:0] prod2_s;
   logic [DW-1:0]           p1_s;
   logic                    p1_sat_s;
   logic [DW-1:0]           p2_s;
   logic                    p2_sat_s;

   assign adv_s    = !out_valid || out_ready;
   assign in_ready = adv_s;

   // Operands are sign-extended to the full product width so nothing wraps.
   assign interp_x_s = {{DW{interp_i[DW-1]}}, interp_i};
   assign lo_x_s     = {{DW{lo_i[DW-1]}}, lo_i};
   assign prod1_s    = interp_x_s * lo_x_s;
   assign p1_x_s     = {{GW{p1_r[DW-1]}}, p1_r};
   assign gain_x_s   = {{DW{gain_r[GW-1]}}, gain_r};
   assign prod2_s    = p1_x_s * gain_x_s;

   mixer_shift_sat #(.IN_W(2*DW), .SHIFT(LO_FRAC), .OUT_W(DW)) u_s1 (
      .din  (prod1_s),
      .dout (p1_s),
      .sat  (p1_sat_s)
   );

   mixer_shift_sat #(.IN_W(DW+GW), .SHIFT(GAIN_FRAC), .OUT_W(DW)) u_s2 (
      .din  (prod2_s),
      .dout (p2_s),
      .sat  (p2_sat_s)
   );

   // Gain register; S2 always reads the registered copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         gain_r <= GAIN_RST;
      end else if (gain_we) begin
         gain_r <= gain_i;
      end else begin
         gain_r <= gain_r;
      end
   end

   // Both stages move together only when the output slot can advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         p1_r       <= {DW{1'b0}};
         s1_sat_r   <= 1'b0;
         out_valid  <= 1'b0;
         mix_o      <= {DW{1'b0}};
         sat_o      <= 1'b0;
      end else if (adv_s) begin
         s1_valid_r <= in_valid;
         out_valid  <= s1_valid_r;
         if (in_valid) begin
            p1_r     <= p1_s;
            s1_sat_r <= p1_sat_s;
         end
         if (s1_valid_r) begin
            mix_o <= p2_s;
            sat_o <= s1_sat_r | p2_sat_s;
         end
      end
   end

   // Saturating count of clipped beats actually handed downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_cnt <= {SAT_CNT_W{1'b0}};
      end else if (out_valid && out_ready && sat_o && (sat_cnt != {SAT_CNT_W{1'b1}})) begin
         sat_cnt <= sat_cnt + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         sat_cnt <= sat_cnt;
      end
   end
endmodule

// File: tb/tb_mixer_pipe.sv
// Scoreboard bench for mixer_pipe: expected beats are queued on acceptance
// and compared on delivery against an integer reference model.
module tb_mixer_pipe;
   localparam int          LO_FRAC   = 15;
   localparam int          GAIN_FRAC = 23;
   localparam longint      MAXV      = 64'sd524287;
   localparam longint      MINV      = -64'sd524288;
   localparam logic [24:0] GAIN_RST  = 25'h028_619A;

   typedef struct {
      logic [19:0] mix;
      logic        sat;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] interp_i;
   logic [19:0] lo_i;
   logic [24:0] gain_i;
   logic        gain_we;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] mix_o;
   logic        sat_o;
   logic [15:0] sat_cnt;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [24:0] mgain;
   logic [15:0] mcnt;
   bit          lat_chk = 1'b0;
   bit          hold_v  = 1'b0;
   logic [19:0] hold_mix;
   exp_t        sb[$];

   mixer_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .interp_i  (interp_i),
      .lo_i      (lo_i),
      .gain_i    (gain_i),
      .gain_we   (gain_we),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mix_o     (mix_o),
      .sat_o     (sat_o),
      .sat_cnt   (sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic longint shsat(input longint v, input int sh, output bit s);
      longint r;
`ifdef MIXER_ROUND_EN
      r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
`else
      r = v >>> sh;
`endif
      s = 1'b0;
      if (r > MAXV) begin
         s = 1'b1;
         r = MAXV;
      end else if (r < MINV) begin
         s = 1'b1;
         r = MINV;
      end
      return r;
   endfunction

   function automatic void model(input logic [19:0] a, input logic [19:0] b,
                                 input logic [24:0] g, output logic [19:0] m, output logic s);
      longint p1, p2;
      bit s1, s2;
      p1 = shsat(longint'($signed(a)) * longint'($signed(b)), LO_FRAC, s1);
      p2 = shsat(p1 * longint'($signed(g)), GAIN_FRAC, s2);
      m  = p2[19:0];
      s  = s1 | s2;
   endfunction

   task automatic step(input logic iv, input logic [19:0] a, input logic [19:0] b,
                       input logic ordy, output logic acc);
      exp_t        e;
      logic [19:0] m;
      logic        s;
      @(negedge clk);
      in_valid  = iv;
      interp_i  = a;
      lo_i      = b;
      out_ready = ordy;
      #1;
      cyc++;
      if (hold_v) check("hold_mix", mix_o, hold_mix);
      check("in_ready", in_ready, (!out_valid) || ordy);
      if (out_valid && ordy) begin
         if (sb.size() == 0) begin
            check("spurious_out", 1, 0);
         end else begin
            e = sb.pop_front();
            check("mix_o", mix_o, e.mix);
            check("sat_o", sat_o, e.sat);
            if (lat_chk) check("latency", cyc, e.cyc + 2);
            if (e.sat && mcnt != 16'hFFFF) mcnt++;
         end
      end
      hold_v   = out_valid && !ordy;
      hold_mix = mix_o;
      acc = iv && in_ready;
      if (acc) begin
         model(a, b, mgain, m, s);
         e.mix = m;
         e.sat = s;
         e.cyc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic send(input logic [19:0] a, input logic [19:0] b);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         step(1'b1, a, b, 1'b1, acc);
         tries++;
      end
      if (!acc) check("accept_timeout", 0, 1);
   endtask

   task automatic drain(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 20'h00000, 20'h00000, 1'b1, acc);
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      gain_we   = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      cyc += 2;
      check("rst_out_valid", out_valid, 0);
      check("rst_mix_o", mix_o, 0);
      check("rst_sat_o", sat_o, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      rst    = 1'b0;
      sb.delete();
      mgain  = GAIN_RST;
      mcnt   = 16'h0000;
      hold_v = 1'b0;
   endtask

   task automatic write_gain(input logic [24:0] g);
      @(negedge clk);
      in_valid = 1'b0;
      gain_i   = g;
      gain_we  = 1'b1;
      @(negedge clk);
      gain_we  = 1'b0;
      mgain    = g;
      cyc += 2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic        acc;
      logic [19:0] ra[8];
      logic [19:0] rb[8];
      int          c;
      int          k;
      int          tries;

      rst = 1'b1; in_valid = 1'b0; interp_i = 20'h0; lo_i = 20'h0;
      gain_i = 25'h0; gain_we = 1'b0; out_ready = 1'b1;
      mgain = GAIN_RST; mcnt = 16'h0;
      do_reset();

      // Nominal sample with exact latency tracking.
      lat_chk = 1'b1;
      send(20'h08000, 20'h08000);
      drain(4);
      lat_chk = 1'b0;

      // Full-scale products: clip in S1, corner negative and -min*-min.
      send(20'h7FFFF, 20'h7FFFF);
      send(20'h80000, 20'h7FFFF);
      send(20'h80000, 20'h80000);
      drain(4);
      check("sat_cnt_after_clip", sat_cnt, mcnt);

      // Unity gain.
      write_gain(25'h0800000);
      send(20'h08000, 20'h08000);
      send(20'h12345, 20'hF0F0F);
      drain(4);

      // Streaming under backpressure on relative cycles 3-5.
      for (int i = 0; i < 8; i++) begin
         ra[i] = 20'($urandom);
         rb[i] = 20'($urandom);
      end
      c = 0;
      k = 0;
      tries = 0;
      while (k < 8 && tries < 40) begin
         step(1'b1, ra[k], rb[k], !(c >= 3 && c <= 5), acc);
         if (c >= 3 && c <= 5) check("stall_in_ready", in_ready, 0);
         if (acc) k++;
         c++;
         tries++;
      end
      if (k < 8) check("stream_timeout", k, 8);
      drain(6);

      // Reset with two samples in flight.
      send(20'h7FFFF, 20'h7FFFF);
      send(20'h01234, 20'h04321);
      do_reset();
      drain(4);
      send(20'h08000, 20'h08000);
      drain(4);

      // Counter saturation.
      @(negedge clk);
      force dut.sat_cnt = 16'hFFFE;
      #1;
      release dut.sat_cnt;
      mcnt = 16'hFFFE;
      for (int i = 0; i < 3; i++) send(20'h7FFFF, 20'h7FFFF);
      drain(4);
      check("sat_cnt_ceiling", sat_cnt, mcnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
